hazard_ctrl_mc: RTL and testbench

//  Second-generation pipeline hazard controller for the 5-stage RV32I core.

---
 rtl/hazard_ctrl_mc_if.sv | 50 +++++
 rtl/hazard_ctrl_mc.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_mc_if.sv
// Hazard-control bundle between the pipeline stage registers and hazard_ctrl_mc.
// The master side is the pipeline, which supplies the hazard inputs. The slave side is the controller.
interface hazard_ctrl_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              ICacheMiss;
    logic              DCacheMiss;
    logic              MduBusyE;
    logic              BranchE;
    logic              JalrE;
    logic              JalD;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [1:0]        RegReadD;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [1:0]        RegReadE;
    logic [REG_AW-1:0] RdE;
    logic [REG_AW-1:0] RdM;
    logic [REG_AW-1:0] RdW;
    logic              MemToRegE;
    logic [2:0]        RegWriteM;
    logic [2:0]        RegWriteW;

    logic StallF, StallD, StallE, StallM, StallW;
    logic FlushF, FlushD, FlushE, FlushM, FlushW;
    logic [1:0]       Forward1E;
    logic [1:0]       Forward2E;
    logic             IMissCancel;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output ICacheMiss, DCacheMiss, MduBusyE, BranchE, JalrE, JalD,
               Rs1D, Rs2D, RegReadD, Rs1E, Rs2E, RegReadE,
               RdE, RdM, RdW, MemToRegE, RegWriteM, RegWriteW,
        input  StallF, StallD, StallE, StallM, StallW,
               FlushF, FlushD, FlushE, FlushM, FlushW,
               Forward1E, Forward2E, IMissCancel, StallCycles
    );

    modport slave (
        input  ICacheMiss, DCacheMiss, MduBusyE, BranchE, JalrE, JalD,
               Rs1D, Rs2D, RegReadD, Rs1E, Rs2E, RegReadE,
               RdE, RdM, RdW, MemToRegE, RegWriteM, RegWriteW,
        output StallF, StallD, StallE, StallM, StallW,
               FlushF, FlushD, FlushE, FlushM, FlushW,
               Forward1E, Forward2E, IMissCancel, StallCycles
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller for the 5-stage RV32I core: stalls, flushes and EX forwarding,
// with multi-cycle stall sources, multi-bubble load-use, post-reset flush and a stall counter.
module hazard_ctrl_mc #(
    parameter int REG_AW        = 5,
    parameter int LU_BUBBLES    = 1,
    parameter int RST_FLUSH_CYC = 2,
    parameter int CNT_W         = 32
) (
    input  logic            CPU_CLK,
    input  logic            CpuRstN,
    hazard_ctrl_mc_if.slave hz
);
    localparam int INIT_W = (RST_FLUSH_CYC > 1) ? $clog2(RST_FLUSH_CYC) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(RST_FLUSH_CYC - 1);
    localparam logic [1:0] LU_LOAD = 2'(LU_BUBBLES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_LU_WAIT
    } state_t;

    state_t            state, next_state;
    logic [1:0]        lu_cnt, next_lu_cnt;
    logic [INIT_W-1:0] init_cnt, next_init_cnt;
    logic              imiss_cancel;
    logic [CNT_W-1:0]  stall_cycles;

    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_f, flush_d, flush_e, flush_m, flush_w;
    logic redirect_hit;
    logic load_use;
    logic [1:0] fwd1, fwd2;

    assign load_use = hz.MemToRegE && (hz.RdE != '0) &&
                      ((hz.RegReadD[1] && (hz.RdE == hz.Rs1D)) ||
                       (hz.RegReadD[0] && (hz.RdE == hz.Rs2D)));

    always_ff @(posedge CPU_CLK or negedge CpuRstN) begin
        if (!CpuRstN) begin
            state    <= ST_INIT;
            lu_cnt   <= '0;
            init_cnt <= '0;
        end else begin
            state    <= next_state;
            lu_cnt   <= next_lu_cnt;
            init_cnt <= next_init_cnt;
        end
    end

    always_comb begin
        next_state    = state;
        next_lu_cnt   = lu_cnt;
        next_init_cnt = init_cnt;
        stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
        flush_f = 1'b0; flush_d = 1'b0; flush_e = 1'b0; flush_m = 1'b0; flush_w = 1'b0;
        redirect_hit = 1'b0;
        unique case (state)
            ST_INIT: begin
                {flush_f, flush_d, flush_e, flush_m, flush_w} = 5'b11111;
                if (init_cnt == INIT_LAST) next_state = ST_RUN;
                else                       next_init_cnt = init_cnt + 1'b1;
            end
            ST_LU_WAIT: begin
                // A D-miss freezes the bubble count so the load-use window resumes afterwards
                if (hz.DCacheMiss) begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    flush_w = 1'b1;
                end else begin
                    stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
                    next_lu_cnt = lu_cnt - 2'd1;
                    if (lu_cnt == 2'd1) next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hz.DCacheMiss) begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    flush_w = 1'b1;
                end else if (hz.MduBusyE) begin
                    {stall_f, stall_d, stall_e} = 3'b111;
                    flush_m = 1'b1;
                end else if (hz.BranchE || hz.JalrE) begin
                    flush_f = 1'b1; flush_d = 1'b1;
                    redirect_hit = 1'b1;
                end else if (load_use) begin
                    stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        next_state  = ST_LU_WAIT;
                        next_lu_cnt = LU_LOAD;
                    end
                end else if (hz.JalD) begin
                    flush_f = 1'b1;
                    redirect_hit = 1'b1;
                end else if (hz.ICacheMiss) begin
                    stall_f = 1'b1; flush_d = 1'b1;
                end
            end
            default: next_state = ST_INIT;
        endcase
    end

    // Forwarding ignores the FSM but is held at 00 while reset is asserted
    always_comb begin
        fwd1 = 2'b00;
        fwd2 = 2'b00;
        if (CpuRstN) begin
            if (hz.RegReadE[1] && (hz.RegWriteM != '0) && (hz.RdM != '0) && (hz.Rs1E == hz.RdM))
                fwd1 = 2'b10;
            else if (hz.RegReadE[1] && (hz.RegWriteW != '0) && (hz.RdW != '0) && (hz.Rs1E == hz.RdW))
                fwd1 = 2'b01;
            if (hz.RegReadE[0] && (hz.RegWriteM != '0) && (hz.RdM != '0) && (hz.Rs2E == hz.RdM))
                fwd2 = 2'b10;
            else if (hz.RegReadE[0] && (hz.RegWriteW != '0) && (hz.RdW != '0) && (hz.Rs2E == hz.RdW))
                fwd2 = 2'b01;
        end
    end

    always_ff @(posedge CPU_CLK or negedge CpuRstN) begin
        if (!CpuRstN) begin
            imiss_cancel <= 1'b0;
            stall_cycles <= '0;
        end else begin
            imiss_cancel <= redirect_hit && hz.ICacheMiss;
            if (stall_f && (state != ST_INIT) && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign hz.StallF      = stall_f;
    assign hz.StallD      = stall_d;
    assign hz.StallE      = stall_e;
    assign hz.StallM      = stall_m;
    assign hz.StallW      = 1'b0;
    assign hz.FlushF      = flush_f;
    assign hz.FlushD      = flush_d;
    assign hz.FlushE      = flush_e;
    assign hz.FlushM      = flush_m;
    assign hz.FlushW      = flush_w;
    assign hz.Forward1E   = fwd1;
    assign hz.Forward2E   = fwd2;
    assign hz.IMissCancel = imiss_cancel;
    assign hz.StallCycles = stall_cycles;
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc with LU_BUBBLES=2 and RST_FLUSH_CYC=2.
// Expected values are hand-derived for each vector.
module tb_hazard_ctrl_mc;
    logic CPU_CLK;
    logic CpuRstN;
    int   checks;
    int   errors;
    int   exp_cycles;

    hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(32)) hz ();

    hazard_ctrl_mc #(
        .REG_AW(5), .LU_BUBBLES(2), .RST_FLUSH_CYC(2), .CNT_W(32)
    ) dut (
        .CPU_CLK (CPU_CLK),
        .CpuRstN (CpuRstN),
        .hz      (hz)
    );

    logic [4:0] stall_v, flush_v;
    assign stall_v = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW};
    assign flush_v = {hz.FlushF, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW};

    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    task automatic next_cycle();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic clear_inputs();
        hz.ICacheMiss = 0; hz.DCacheMiss = 0; hz.MduBusyE = 0;
        hz.BranchE = 0; hz.JalrE = 0; hz.JalD = 0;
        hz.Rs1D = 0; hz.Rs2D = 0; hz.RegReadD = 0;
        hz.Rs1E = 0; hz.Rs2E = 0; hz.RegReadE = 0;
        hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
        hz.MemToRegE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        CpuRstN = 0;
        next_cycle();
        checks++; if (flush_v !== 5'b11111) begin errors++; $display("[TB] FAIL reset_flush: got %b expected 11111", flush_v); end
        checks++; if (stall_v !== 5'b00000) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 00000", stall_v); end
        checks++; if ({hz.Forward1E, hz.Forward2E, hz.IMissCancel} !== 5'b00000) begin errors++; $display("[TB] FAIL reset_fwd_cancel: got %b expected 00000", {hz.Forward1E, hz.Forward2E, hz.IMissCancel}); end
        checks++; if (hz.StallCycles !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", hz.StallCycles); end
        CpuRstN = 1;
        exp_cycles = 0;
        // Inputs that would normally stall must be ignored during the flush sequence
        hz.ICacheMiss = 1;
        #1;
        checks++; if (flush_v !== 5'b11111 || stall_v !== 5'b00000) begin errors++; $display("[TB] FAIL init_edge0: got flush %b stall %b expected 11111 00000", flush_v, stall_v); end
        next_cycle();
        checks++; if (flush_v !== 5'b11111 || stall_v !== 5'b00000) begin errors++; $display("[TB] FAIL init_edge1: got flush %b stall %b expected 11111 00000", flush_v, stall_v); end
        hz.ICacheMiss = 0;
        next_cycle();
        checks++; if (flush_v !== 5'b00000 || stall_v !== 5'b00000) begin errors++; $display("[TB] FAIL init_done: got flush %b stall %b expected 00000 00000", flush_v, stall_v); end
        checks++; if (hz.StallCycles !== 32'd0) begin errors++; $display("[TB] FAIL init_count: got %0d expected 0", hz.StallCycles); end
    endtask

    task automatic test_load_use();
        hz.MemToRegE = 1; hz.RdE = 5; hz.Rs2D = 5; hz.RegReadD = 2'b01;
        #1;
        checks++; if (stall_v !== 5'b11000 || flush_v !== 5'b00100) begin errors++; $display("[TB] FAIL lu_bubble1: got stall %b flush %b expected 11000 00100", stall_v, flush_v); end
        next_cycle();
        exp_cycles++;
        hz.MemToRegE = 0; hz.RdE = 0; hz.Rs2D = 0; hz.RegReadD = 0;
        #1;
        checks++; if (stall_v !== 5'b11000 || flush_v !== 5'b00100) begin errors++; $display("[TB] FAIL lu_bubble2: got stall %b flush %b expected 11000 00100", stall_v, flush_v); end
        next_cycle();
        exp_cycles++;
        checks++; if (stall_v !== 5'b00000 || flush_v !== 5'b00000) begin errors++; $display("[TB] FAIL lu_release: got stall %b flush %b expected 00000 00000", stall_v, flush_v); end
        checks++; if (hz.StallCycles !== exp_cycles) begin errors++; $display("[TB] FAIL lu_count: got %0d expected %0d", hz.StallCycles, exp_cycles); end
        hz.MemToRegE = 1; hz.RdE = 5; hz.Rs2D = 5; hz.RegReadD = 2'b00;
        #1;
        checks++; if (stall_v !== 5'b00000 || flush_v !== 5'b00000) begin errors++; $display("[TB] FAIL lu_unused_src: got stall %b flush %b expected 00000 00000", stall_v, flush_v); end
        hz.RdE = 0; hz.Rs2D = 0; hz.RegReadD = 2'b01;
        #1;
        checks++; if (stall_v !== 5'b00000) begin errors++; $display("[TB] FAIL lu_x0: got stall %b expected 00000", stall_v); end
        hz.RdE = 9; hz.Rs1D = 9; hz.RegReadD = 2'b10;
        #1;
        checks++; if (stall_v !== 5'b11000 || flush_v !== 5'b00100) begin errors++; $display("[TB] FAIL lu_rs1: got stall %b flush %b expected 11000 00100", stall_v, flush_v); end
        clear_inputs();
        #1;
    endtask

    task automatic test_dcache_miss();
        hz.BranchE = 1; hz.DCacheMiss = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (stall_v !== 5'b11110 || flush_v !== 5'b00001) begin errors++; $display("[TB] FAIL dmiss_cycle%0d: got stall %b flush %b expected 11110 00001", i, stall_v, flush_v); end
            next_cycle();
            exp_cycles++;
        end
        hz.DCacheMiss = 0;
        #1;
        checks++; if (stall_v !== 5'b00000 || flush_v !== 5'b11000) begin errors++; $display("[TB] FAIL dmiss_branch: got stall %b flush %b expected 00000 11000", stall_v, flush_v); end
        checks++; if (hz.StallCycles !== exp_cycles) begin errors++; $display("[TB] FAIL dmiss_count: got %0d expected %0d", hz.StallCycles, exp_cycles); end
        hz.BranchE = 0; hz.MduBusyE = 1; hz.JalrE = 1;
        #1;
        checks++; if (stall_v !== 5'b11100 || flush_v !== 5'b00010) begin errors++; $display("[TB] FAIL mdu_busy: got stall %b flush %b expected 11100 00010", stall_v, flush_v); end
        next_cycle();
        exp_cycles++;
        clear_inputs();
        #1;
    endtask

    task automatic test_imiss_cancel();
        hz.ICacheMiss = 1;
        #1;
        checks++; if (stall_v !== 5'b10000 || flush_v !== 5'b01000) begin errors++; $display("[TB] FAIL imiss_stall: got stall %b flush %b expected 10000 01000", stall_v, flush_v); end
        next_cycle();
        exp_cycles++;
        hz.JalD = 1;
        #1;
        checks++; if (stall_v !== 5'b00000 || flush_v !== 5'b10000 || hz.IMissCancel !== 1'b0) begin errors++; $display("[TB] FAIL jal_redirect: got stall %b flush %b cancel %b expected 00000 10000 0", stall_v, flush_v, hz.IMissCancel); end
        next_cycle();
        hz.JalD = 0; hz.ICacheMiss = 0;
        #1;
        checks++; if (hz.IMissCancel !== 1'b1) begin errors++; $display("[TB] FAIL cancel_pulse: got %b expected 1", hz.IMissCancel); end
        next_cycle();
        checks++; if (hz.IMissCancel !== 1'b0) begin errors++; $display("[TB] FAIL cancel_single: got %b expected 0", hz.IMissCancel); end
        hz.JalD = 1;
        next_cycle();
        checks++; if (hz.IMissCancel !== 1'b0) begin errors++; $display("[TB] FAIL cancel_no_miss: got %b expected 0", hz.IMissCancel); end
        clear_inputs();
        checks++; if (hz.StallCycles !== exp_cycles) begin errors++; $display("[TB] FAIL imiss_count: got %0d expected %0d", hz.StallCycles, exp_cycles); end
    endtask

    task automatic test_forwarding();
        hz.Rs1E = 7; hz.RdM = 7; hz.RdW = 7; hz.RegWriteM = 3'b001; hz.RegWriteW = 3'b100; hz.RegReadE = 2'b10;
        #1;
        checks++; if (hz.Forward1E !== 2'b10 || hz.Forward2E !== 2'b00) begin errors++; $display("[TB] FAIL fwd_mem: got %b %b expected 10 00", hz.Forward1E, hz.Forward2E); end
        hz.RdM = 0;
        #1;
        checks++; if (hz.Forward1E !== 2'b01) begin errors++; $display("[TB] FAIL fwd_wb: got %b expected 01", hz.Forward1E); end
        hz.RegReadE = 2'b00;
        #1;
        checks++; if (hz.Forward1E !== 2'b00) begin errors++; $display("[TB] FAIL fwd_unused: got %b expected 00", hz.Forward1E); end
        hz.RegReadE = 2'b01; hz.Rs2E = 9; hz.RdW = 9; hz.RdM = 9; hz.RegWriteM = 3'b000;
        #1;
        checks++; if (hz.Forward2E !== 2'b01 || hz.Forward1E !== 2'b00) begin errors++; $display("[TB] FAIL fwd2_wb: got %b %b expected 00 01", hz.Forward1E, hz.Forward2E); end
        hz.RegWriteW = 3'b000;
        #1;
        checks++; if (hz.Forward2E !== 2'b00) begin errors++; $display("[TB] FAIL fwd2_nowrite: got %b expected 00", hz.Forward2E); end
        hz.Rs2E = 0; hz.RdW = 0; hz.RdM = 0; hz.RegWriteW = 3'b010; hz.RegWriteM = 3'b010;
        #1;
        checks++; if (hz.Forward2E !== 2'b00) begin errors++; $display("[TB] FAIL fwd_x0: got %b expected 00", hz.Forward2E); end
        clear_inputs();
        #1;
    endtask

    task automatic test_lu_dmiss_freeze();
        hz.MemToRegE = 1; hz.RdE = 3; hz.Rs1D = 3; hz.RegReadD = 2'b10;
        next_cycle();
        exp_cycles++;
        clear_inputs();
        hz.DCacheMiss = 1;
        #1;
        checks++; if (stall_v !== 5'b11110 || flush_v !== 5'b00001) begin errors++; $display("[TB] FAIL lu_dmiss: got stall %b flush %b expected 11110 00001", stall_v, flush_v); end
        next_cycle();
        next_cycle();
        exp_cycles += 2;
        hz.DCacheMiss = 0;
        #1;
        checks++; if (stall_v !== 5'b11000 || flush_v !== 5'b00100) begin errors++; $display("[TB] FAIL lu_resume: got stall %b flush %b expected 11000 00100", stall_v, flush_v); end
        next_cycle();
        exp_cycles++;
        checks++; if (stall_v !== 5'b00000 || flush_v !== 5'b00000) begin errors++; $display("[TB] FAIL lu_resume_done: got stall %b flush %b expected 00000 00000", stall_v, flush_v); end
        checks++; if (hz.StallCycles !== exp_cycles) begin errors++; $display("[TB] FAIL freeze_count: got %0d expected %0d", hz.StallCycles, exp_cycles); end
    endtask

    task automatic test_reset_mid_lu();
        hz.MemToRegE = 1; hz.RdE = 5; hz.Rs2D = 5; hz.RegReadD = 2'b01;
        next_cycle();
        clear_inputs();
        #2;
        CpuRstN = 0;
        #1;
        checks++; if (flush_v !== 5'b11111 || stall_v !== 5'b00000) begin errors++; $display("[TB] FAIL async_reset: got flush %b stall %b expected 11111 00000", flush_v, stall_v); end
        checks++; if (hz.StallCycles !== 32'd0) begin errors++; $display("[TB] FAIL async_count: got %0d expected 0", hz.StallCycles); end
        next_cycle();
        CpuRstN = 1;
        next_cycle();
        next_cycle();
        checks++; if (flush_v !== 5'b00000 || stall_v !== 5'b00000) begin errors++; $display("[TB] FAIL rerun: got flush %b stall %b expected 00000 00000", flush_v, stall_v); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cycles = 0;
        CpuRstN = 0;
        test_reset();
        test_load_use();
        test_dcache_miss();
        test_imiss_cancel();
        test_forwarding();
        test_lu_dmiss_freeze();
        test_reset_mid_lu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
